// File: rtl/core_load_sched.sv
// rtl/core_load_sched.sv - round-robin scheduler that streams 16-word blocks into MD5 core input slots
module core_load_sched #(
  parameter int N_CORES    = 3,
  parameter int BLK_OP_MSB = 3,
  parameter int CORE_MSB   = (N_CORES > 1) ? $clog2(N_CORES) - 1 : 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_ctx,
  input  logic                    req_seq,
  input  logic [BLK_OP_MSB:0]     req_blk_op,
  output logic                    src_rd_en,
  output logic [3:0]              src_rd_addr,
  input  logic [31:0]             src_data,
  input  logic [4*N_CORES-1:0]    core_ready,
  output logic [N_CORES-1:0]      core_wr_en,
  output logic [3:0]              core_wr_addr,
  output logic [31:0]             core_din,
  output logic [BLK_OP_MSB:0]     core_blk_op,
  output logic                    core_input_ctx,
  output logic                    core_input_seq,
  output logic                    core_set_input_ready,
  output logic                    done,
  output logic [CORE_MSB:0]       done_core,
  output logic                    err
);

  localparam int                  CW       = CORE_MSB + 1;
  localparam logic [CORE_MSB:0]   LAST_IDX = CW'(N_CORES - 1);
  localparam logic [N_CORES-1:0]  ONE_HOT0 = N_CORES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_DRAIN,
    S_SET
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_rdy_en;
  logic                 r_ctx;
  logic                 r_seq;
  logic [BLK_OP_MSB:0]  r_blk_op;
  logic [CORE_MSB:0]    r_sel_core;
  logic [CORE_MSB:0]    r_last_core;
  logic [3:0]           r_cnt;
  logic                 r_wr_vld;
  logic [3:0]           r_wr_addr;
  logic                 r_err;

  logic [1:0]           w_slot;
  logic [3:0]           w_nib [N_CORES];
  logic [N_CORES-1:0]   w_avail;
  logic                 w_found;
  logic [CORE_MSB:0]    w_pick;
  logic [CORE_MSB:0]    w_idx;
  logic                 w_accept;
  logic                 w_loading;

  // Slot within each core's 4-bit ready group is selected by {seq, ctx}.
  assign w_slot = {r_seq, r_ctx};

  for (genvar g = 0; g < N_CORES; g++) begin : g_avail
    assign w_nib[g]   = core_ready[4*g +: 4];
    assign w_avail[g] = w_nib[g][w_slot];
  end

  assign req_ready = (r_state == S_IDLE) && r_rdy_en;
  assign w_accept  = req_valid && req_ready;
  assign w_loading = (r_state == S_LOAD) || (r_state == S_DRAIN);

  assign src_rd_en            = (r_state == S_LOAD);
  assign src_rd_addr          = r_cnt;
  assign core_wr_en           = r_wr_vld ? (ONE_HOT0 << r_sel_core) : '0;
  assign core_wr_addr         = r_wr_addr;
  assign core_din             = r_wr_vld ? src_data : '0;
  assign core_blk_op          = r_blk_op;
  assign core_input_ctx       = r_ctx;
  assign core_input_seq       = r_seq;
  assign core_set_input_ready = (r_state == S_SET);
  assign done                 = (r_state == S_SET);
  assign done_core            = done ? r_sel_core : '0;
  assign err                  = r_err;

  // Round-robin scan starting just after the last granted core.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = r_last_core;
    for (int k = 0; k < N_CORES; k++) begin
      w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
      if (!w_found && w_avail[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Next-state logic for IDLE -> SELECT -> LOAD -> DRAIN -> SET.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SELECT;
      S_SELECT: if (w_found) w_next = S_LOAD;
      S_LOAD:   if (r_cnt == 4'hF) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_SET;
      S_SET:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Hold req_ready low until the first clock after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Capture request tags on accept; they stay put until the next accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ctx    <= 1'b0;
      r_seq    <= 1'b0;
      r_blk_op <= '0;
    end else if (w_accept) begin
      r_ctx    <= req_ctx;
      r_seq    <= req_seq;
      r_blk_op <= req_blk_op;
    end
  end

  // Record the chosen core, and advance the round-robin pointer on completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sel_core  <= '0;
      r_last_core <= LAST_IDX;
    end else begin
      if (r_state == S_SELECT && w_found) r_sel_core <= w_pick;
      if (r_state == S_SET)               r_last_core <= r_sel_core;
    end
  end

  // Word counter for the 16 source reads; wraps back to 0 after word 15.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                          r_cnt <= '0;
    else if (r_state == S_SELECT)        r_cnt <= '0;
    else if (r_state == S_LOAD)          r_cnt <= r_cnt + 4'd1;
  end

  // Core writes trail source reads by one cycle to match source read latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_vld  <= (r_state == S_LOAD);
      r_wr_addr <= (r_state == S_LOAD) ? r_cnt : '0;
    end
  end

  // Sticky flag: the target slot disappeared while its block was being written.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                            r_err <= 1'b0;
    else if (w_loading && !w_avail[r_sel_core]) r_err <= 1'b1;
  end

endmodule
